debug_unit: RTL and testbench

- Host-side control stage directly upstream of datapath_pipe.
- Takes a UART byte stream and loads program words into instruction memory.
- Gates the pipeline with a global enable for continuous or single-step execution.
- Streams PC and register bank back over UART after halt or after each step.

---
 rtl/debug_unit.sv | 158 +++++++++++++++
 tb/tb_debug_unit.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/debug_unit.sv
// Host debug controller: UART program loader, run/step gate for the pipeline,
// and PC/register-bank dump back over UART.
module debug_unit #(
   parameter int NBITS     = 32,
   parameter int RBITS     = 5,
   parameter int MEM_SIZE  = 7,
   parameter int BANK_SIZE = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [7:0]          i_rx_data,
   input  logic                i_rx_valid,
   output logic [7:0]          o_tx_data,
   output logic                o_tx_start,
   input  logic                i_tx_done,
   output logic                o_imem_we,
   output logic [MEM_SIZE-1:0] o_imem_addr,
   output logic [NBITS-1:0]    o_imem_data,
   output logic                o_cpu_en,
   output logic                o_cpu_rst,
   output logic [RBITS-1:0]    o_reg_addr,
   input  logic [NBITS-1:0]    i_reg_data,
   input  logic [NBITS-1:0]    i_pc,
   input  logic                i_halt
);

   localparam int NB = NBITS / 8;
   localparam int BW = (NB > 1) ? $clog2(NB) : 1;
   localparam int WW = $clog2(BANK_SIZE + 1);

   localparam logic [7:0] CMD_LOAD = 8'h4C;
   localparam logic [7:0] CMD_CONT = 8'h43;
   localparam logic [7:0] CMD_STEP = 8'h53;

   localparam logic [3:0] S_IDLE   = 4'd0;
   localparam logic [3:0] S_LCNT   = 4'd1;
   localparam logic [3:0] S_LBYTES = 4'd2;
   localparam logic [3:0] S_WRITE  = 4'd3;
   localparam logic [3:0] S_LEND   = 4'd4;
   localparam logic [3:0] S_RUN    = 4'd5;
   localparam logic [3:0] S_STEP   = 4'd6;
   localparam logic [3:0] S_DFETCH = 4'd7;
   localparam logic [3:0] S_DLATCH = 4'd8;
   localparam logic [3:0] S_DSEND  = 4'd9;
   localparam logic [3:0] S_DWAIT  = 4'd10;

   logic [3:0]          r_state;
   logic [7:0]          r_cnt;
   logic [MEM_SIZE-1:0] r_addr;
   logic [BW-1:0]       r_bidx;
   logic [NBITS-1:0]    r_shift;
   logic [NBITS-1:0]    r_word;
   logic [WW-1:0]       r_widx;
   logic [RBITS-1:0]    r_reg_addr;
   logic                r_halted;

   logic w_last_byte;
   assign w_last_byte = (r_bidx == BW'(NB - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_addr     <= '0;
         r_bidx     <= '0;
         r_shift    <= '0;
         r_word     <= '0;
         r_widx     <= '0;
         r_reg_addr <= '0;
         r_halted   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_rx_valid) begin
                  if (i_rx_data == CMD_LOAD) begin
                     r_state <= S_LCNT;
                     r_addr  <= '0;
                     r_bidx  <= '0;
                  end else if (i_rx_data == CMD_CONT && !r_halted) begin
                     r_state <= S_RUN;
                  end else if (i_rx_data == CMD_STEP && !r_halted) begin
                     r_state <= S_STEP;
                  end
               end
            end
            S_LCNT: begin
               if (i_rx_valid) begin
                  r_cnt   <= i_rx_data;
                  r_bidx  <= '0;
                  r_state <= (i_rx_data == 8'd0) ? S_LEND : S_LBYTES;
               end
            end
            S_LBYTES: begin
               if (i_rx_valid) begin
                  r_shift <= (r_shift << 8) | NBITS'(i_rx_data);
                  if (w_last_byte) r_state <= S_WRITE;
                  else             r_bidx  <= r_bidx + 1'b1;
               end
            end
            S_WRITE: begin
               r_addr  <= r_addr + 1'b1;
               r_cnt   <= r_cnt - 8'd1;
               r_bidx  <= '0;
               r_state <= (r_cnt == 8'd1) ? S_LEND : S_LBYTES;
            end
            S_LEND: begin
               r_halted <= 1'b0;
               r_state  <= S_IDLE;
            end
            S_RUN, S_STEP: begin
               if (i_halt) r_halted <= 1'b1;
               // STEP always leaves after its single enabled cycle
               if (i_halt || r_state == S_STEP) begin
                  r_word     <= i_pc;
                  r_bidx     <= '0;
                  r_widx     <= '0;
                  r_reg_addr <= '0;
                  r_state    <= S_DSEND;
               end
            end
            S_DFETCH: r_state <= S_DLATCH;
            S_DLATCH: begin
               r_word  <= i_reg_data;
               r_bidx  <= '0;
               r_state <= S_DSEND;
            end
            S_DSEND: r_state <= S_DWAIT;
            S_DWAIT: begin
               if (i_tx_done) begin
                  if (!w_last_byte) begin
                     r_word  <= r_word << 8;
                     r_bidx  <= r_bidx + 1'b1;
                     r_state <= S_DSEND;
                  end else if (r_widx == WW'(BANK_SIZE)) begin
                     r_state <= S_IDLE;
                  end else begin
                     // word 0 is the PC, so the register address only moves after a register word
                     if (r_widx != '0) r_reg_addr <= r_reg_addr + 1'b1;
                     r_widx  <= r_widx + 1'b1;
                     r_state <= S_DFETCH;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_imem_we   = (r_state == S_WRITE);
   assign o_imem_addr = r_addr;
   assign o_imem_data = r_shift;
   assign o_cpu_en    = (r_state == S_RUN) || (r_state == S_STEP);
   assign o_cpu_rst   = (r_state == S_LEND);
   assign o_tx_start  = (r_state == S_DSEND);
   assign o_tx_data   = r_word[NBITS-1 -: 8];
   assign o_reg_addr  = r_reg_addr;

endmodule

// File: tb/tb_debug_unit.sv
// Self-checking bench for debug_unit: command table, loads checked against an
// address/word model, dumps checked against the PC/register byte stream.
module tb_debug_unit;
   localparam int NBITS = 32, RBITS = 5, MEM_SIZE = 7, BANK_SIZE = 32;
   localparam int DUMP_LEN = 4 + 4 * BANK_SIZE;

   logic clk = 0, rst = 0;
   logic [7:0] i_rx_data = 0;
   logic i_rx_valid = 0, i_tx_done = 0, i_halt = 0;
   logic [NBITS-1:0] i_reg_data = 0, i_pc = 0;
   logic [7:0] o_tx_data;
   logic o_tx_start, o_imem_we, o_cpu_en, o_cpu_rst;
   logic [MEM_SIZE-1:0] o_imem_addr;
   logic [NBITS-1:0] o_imem_data;
   logic [RBITS-1:0] o_reg_addr;

   debug_unit #(.NBITS(NBITS), .RBITS(RBITS), .MEM_SIZE(MEM_SIZE), .BANK_SIZE(BANK_SIZE)) dut (
      .clk(clk), .rst(rst), .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
      .o_tx_data(o_tx_data), .o_tx_start(o_tx_start), .i_tx_done(i_tx_done),
      .o_imem_we(o_imem_we), .o_imem_addr(o_imem_addr), .o_imem_data(o_imem_data),
      .o_cpu_en(o_cpu_en), .o_cpu_rst(o_cpu_rst), .o_reg_addr(o_reg_addr),
      .i_reg_data(i_reg_data), .i_pc(i_pc), .i_halt(i_halt));

   always #5 clk = ~clk;

   int n_checks = 0, n_errors = 0;
   int wr_cnt = 0, rst_cnt = 0, en_cnt = 0, cmd_en = 0, halt_at = 0, tx_dly = 0;
   bit tx_busy = 0;
   logic [7:0] tx_q[$];
   int wa_q[$];
   logic [NBITS-1:0] wd_q[$];
   logic [NBITS-1:0] ld_words[$];
   logic [NBITS-1:0] reg_base = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // register bank model: reg k reads back reg_base+k one cycle after the address
   always @(posedge clk) i_reg_data <= reg_base + NBITS'(o_reg_addr);

   // output monitor plus UART transmitter and halt responder
   initial forever begin
      @(negedge clk);
      if (o_imem_we) begin wr_cnt++; wa_q.push_back(int'(o_imem_addr)); wd_q.push_back(o_imem_data); end
      if (o_cpu_rst) rst_cnt++;
      if (o_cpu_en) begin
         en_cnt++; cmd_en++;
         if (halt_at != 0 && cmd_en == halt_at) i_halt = 1;
      end
      if (i_tx_done) begin i_tx_done = 0; tx_busy = 0; end
      if (o_tx_start) begin
         check("tx_overlap", {63'd0, tx_busy}, 64'd0);
         tx_q.push_back(o_tx_data);
         tx_busy = 1;
         tx_dly = $urandom_range(1, 4);
      end else if (tx_busy) begin
         if (tx_dly == 0) i_tx_done = 1;
         else tx_dly--;
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk); i_rx_data = b; i_rx_valid = 1;
      @(negedge clk); i_rx_valid = 0;
      idle(2);
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk); rst = 1;
      @(negedge clk);
      check({tag, "_ctl"}, {o_imem_we, o_cpu_en, o_cpu_rst, o_tx_start, o_tx_data, o_reg_addr, o_imem_addr}, 64'd0);
      check({tag, "_data"}, o_imem_data, 64'd0);
      @(negedge clk); rst = 0;
   endtask

   task automatic run_load(input string tag, input int n);
      int r0, e0, bad;
      wa_q.delete(); wd_q.delete();
      r0 = rst_cnt; e0 = en_cnt; bad = 0;
      send_byte(8'h4C);
      send_byte(8'(n));
      for (int i = 0; i < n; i++)
         for (int b = 0; b < 4; b++) send_byte(ld_words[i][31-8*b -: 8]);
      idle(10);
      check({tag, "_nwr"}, wa_q.size(), n);
      for (int i = 0; i < n && i < wa_q.size(); i++)
         if (wa_q[i] != (i % (1 << MEM_SIZE)) || wd_q[i] !== ld_words[i]) bad++;
      check({tag, "_words"}, bad, 0);
      check({tag, "_cpurst"}, rst_cnt - r0, 1);
      check({tag, "_cpuen"}, en_cnt - e0, 0);
   endtask

   typedef struct {
      logic [7:0] cmd;
      logic [7:0] cnt;
      int halt_at;
      bit inject;
      bit fixed;
      int exp_en;
      int exp_tx;
      int exp_rst;
   } vec_t;
   vec_t tbl[12];

   initial begin
      logic [7:0] inj[4];
      inj[0] = 8'h4C; inj[1] = 8'h43; inj[2] = 8'h53; inj[3] = 8'h00;

      tbl[0]  = '{8'h7A, 8'd0, 0,  0, 0, 0,  0,        0};
      tbl[1]  = '{8'h53, 8'd0, 0,  0, 1, 1,  DUMP_LEN, 0};
      tbl[2]  = '{8'h43, 8'd0, 20, 1, 0, 20, DUMP_LEN, 0};
      tbl[3]  = '{8'h53, 8'd0, 0,  0, 0, 0,  0,        0};
      tbl[4]  = '{8'h43, 8'd0, 0,  0, 0, 0,  0,        0};
      tbl[5]  = '{8'h4C, 8'd0, 0,  0, 0, 0,  0,        1};
      tbl[6]  = '{8'h53, 8'd0, 1,  0, 0, 1,  DUMP_LEN, 0};
      tbl[7]  = '{8'h43, 8'd0, 0,  0, 0, 0,  0,        0};
      tbl[8]  = '{8'h4C, 8'd0, 0,  0, 0, 0,  0,        1};
      tbl[9]  = '{8'h43, 8'd0, 5,  1, 0, 5,  DUMP_LEN, 0};
      tbl[10] = '{8'h4C, 8'd0, 0,  0, 0, 0,  0,        1};
      tbl[11] = '{8'h53, 8'd0, 0,  1, 0, 1,  DUMP_LEN, 0};

      do_reset("reset");

      ld_words = '{32'h20010005, 32'hAC010004};
      run_load("load2", 2);

      // reset in the middle of a word must discard it and restart at address 0
      wa_q.delete(); wd_q.delete();
      send_byte(8'h4C); send_byte(8'h02); send_byte(8'hAA); send_byte(8'hBB);
      do_reset("midrst");
      idle(20);
      check("midrst_nowr", wa_q.size(), 0);
      ld_words = '{32'h11223344};
      run_load("postrst", 1);

      foreach (tbl[k]) begin
         int e0, t0, r0, w0, t, bad;
         string nm;
         nm = $sformatf("v%0d", k);
         i_pc     = tbl[k].fixed ? 32'h4 : $urandom;
         reg_base = tbl[k].fixed ? 32'h0 : $urandom;
         tx_q.delete();
         e0 = en_cnt; r0 = rst_cnt; w0 = wr_cnt; t0 = 0;
         cmd_en = 0; halt_at = tbl[k].halt_at;
         send_byte(tbl[k].cmd);
         if (tbl[k].cmd == 8'h4C) send_byte(tbl[k].cnt);
         if (tbl[k].exp_tx > 0) begin
            t = 0;
            while ((tx_q.size() < tbl[k].exp_tx || tx_busy) && t < 6000) begin
               @(negedge clk); t++;
               i_rx_valid = 0;
               if (tbl[k].inject && t % 29 == 3 && tx_q.size() >= 1 && tx_q.size() < tbl[k].exp_tx - 2) begin
                  i_rx_data = inj[$urandom_range(0, 3)]; i_rx_valid = 1;
               end
            end
            i_rx_valid = 0;
            check({nm, "_timeout"}, t >= 6000, 0);
            idle(5);
         end else idle(60);
         check({nm, "_en"}, en_cnt - e0, tbl[k].exp_en);
         check({nm, "_ntx"}, tx_q.size(), tbl[k].exp_tx);
         check({nm, "_cpurst"}, rst_cnt - r0, tbl[k].exp_rst);
         check({nm, "_nwr"}, wr_cnt - w0, 0);
         if (tbl[k].exp_tx > 0) begin
            bad = 0;
            for (int j = 0; j < DUMP_LEN / 4; j++) begin
               logic [31:0] w;
               w = (j == 0) ? i_pc : reg_base + 32'(j - 1);
               for (int b = 0; b < 4; b++)
                  if (4*j + b < tx_q.size() && tx_q[4*j + b] !== w[31-8*b -: 8]) bad++;
            end
            check({nm, "_dump"}, bad, 0);
         end
         i_halt = 0; halt_at = 0;
      end

      for (int it = 0; it < 4; it++) begin
         int n, a0;
         logic [7:0] j;
         j = 8'($urandom);
         if (j == 8'h4C || j == 8'h43 || j == 8'h53) j = j ^ 8'h80;
         a0 = wr_cnt + rst_cnt + en_cnt + tx_q.size();
         send_byte(j);
         idle(10);
         check($sformatf("junk%0d", it), wr_cnt + rst_cnt + en_cnt + tx_q.size() - a0, 0);
         n = $urandom_range(1, 6);
         ld_words.delete();
         for (int i = 0; i < n; i++) ld_words.push_back($urandom);
         run_load($sformatf("rload%0d", it), n);
      end

      ld_words.delete();
      for (int i = 0; i < 129; i++) ld_words.push_back($urandom);
      run_load("wrap", 129);
      if (wa_q.size() == 129) begin
         check("wrap_last_addr", wa_q[128], 0);
         check("wrap_last_data", wd_q[128], ld_words[128]);
      end else check("wrap_count", wa_q.size(), 129);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
